// File: rtl/path_sequencer.sv
// Initiator for the Path datapath: accepts commands over valid/ready, drives operands,
// waits the datapath latency, captures y and queues results in a small FIFO.
module path_sequencer #(
  parameter int DW    = 8,
  parameter int OPW   = 4,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [DW-1:0]  cmd_a,
  input  logic [DW-1:0]  cmd_b,
  input  logic [OPW-1:0] cmd_op,
  input  logic           cmd_s,
  output logic [DW-1:0]  dp_inA,
  output logic [DW-1:0]  dp_inB,
  output logic [OPW-1:0] dp_op,
  output logic           dp_s,
  input  logic [DW:0]    dp_y,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW:0]    res_y,
  output logic           busy,
  output logic [7:0]     done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  a_q, b_q;
  logic [OPW-1:0] op_q;
  logic           s_q;
  logic [7:0]     done_q;
  logic [DW:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic [AW+1:0]  occupancy;
  logic           in_flight, cmd_fire, push, pop;

  // The slot for a result is reserved at accept, so CAP never meets a full FIFO.
  assign in_flight = (state_q != S_IDLE);
  assign occupancy = {1'b0, count_q} + (AW+2)'(in_flight);
  assign cmd_ready = (state_q == S_IDLE) && (occupancy < (AW+2)'(DEPTH));
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign push      = (state_q == S_CAP);
  assign pop       = res_ready && (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      s_q     <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cmd_fire) begin
        a_q  <= cmd_a;
        b_q  <= cmd_b;
        op_q <= cmd_op;
        s_q  <= cmd_s;
      end
      if (push) done_q <= done_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dp_y;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dp_inA    = a_q;
  assign dp_inB    = b_q;
  assign dp_op     = op_q;
  assign dp_s      = s_q;
  assign res_valid = (count_q != '0);
  assign res_y     = mem_q[rd_ptr_q];
  assign busy      = (state_q != S_IDLE);
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_path_sequencer.sv
// Bench for path_sequencer with a one-cycle behavioural Path stub (add / and).
module tb_path_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_op;
  logic       cmd_s;
  logic [7:0] dp_inA, dp_inB;
  logic [3:0] dp_op;
  logic       dp_s;
  logic [8:0] dp_y;
  logic       res_valid, res_ready;
  logic [8:0] res_y;
  logic       busy;
  logic [7:0] done_cnt;

  int total = 0;
  int bad = 0;
  int viol = 0;
  int exp_done = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       s;
    logic [8:0] y;
  } vec_t;
  vec_t vecs[8];

  path_sequencer #(.DW(8), .OPW(4), .LAT(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_s(cmd_s),
    .dp_inA(dp_inA), .dp_inB(dp_inB), .dp_op(dp_op), .dp_s(dp_s),
    .dp_y(dp_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (dp_op)
      4'h0:    dp_y <= {1'b0, dp_inA} + {1'b0, dp_inB};
      4'h1:    dp_y <= {1'b0, dp_inA & dp_inB};
      default: dp_y <= '0;
    endcase
  end

  always @(negedge clk) if (busy && cmd_ready) viol++;

  function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    if (op == 4'h0) return {1'b0, a} + {1'b0, b};
    if (op == 4'h1) return {1'b0, a & b};
    return 9'h000;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic issue(logic [7:0] a, logic [7:0] b, logic [3:0] op, logic s);
    int n = 0;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_s = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      total++; bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 30 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(int idx);
    res_ready = 1'b1;
    issue(vecs[idx].a, vecs[idx].b, vecs[idx].op, vecs[idx].s);
    exp_done = (exp_done + 1) % 256;
    chk($sformatf("v%0d_dp_inA", idx), 32'(dp_inA), 32'(vecs[idx].a));
    chk($sformatf("v%0d_dp_inB", idx), 32'(dp_inB), 32'(vecs[idx].b));
    chk($sformatf("v%0d_dp_op_s", idx), {27'd0, dp_op, dp_s}, {27'd0, vecs[idx].op, vecs[idx].s});
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_early_valid", idx), 32'(res_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_res_valid", idx), 32'(res_valid), 32'd1);
    chk($sformatf("v%0d_res_y", idx), 32'(res_y), 32'(vecs[idx].y));
    chk($sformatf("v%0d_done_cnt", idx), 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic drain(string nm, int exp_n);
    int n = 0;
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!res_valid) break;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s_extra: got result %0h expected none", nm, res_y);
      end else begin
        chk($sformatf("%s_y%0d", nm, n), 32'(res_y), 32'(exp_q.pop_front()));
      end
      n++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk($sformatf("%s_count", nm), 32'(n), 32'(exp_n));
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'hF0, 4'h0, 1'b1, 9'h0FF};
    vecs[1] = '{8'hFF, 8'h01, 4'h0, 1'b0, 9'h100};
    vecs[2] = '{8'h0F, 8'hF0, 4'h1, 1'b0, 9'h000};
    vecs[3] = '{8'hAA, 8'h55, 4'h1, 1'b1, 9'h000};
    vecs[4] = '{8'h80, 8'h80, 4'h0, 1'b0, 9'h100};
    vecs[5] = '{8'h3C, 8'h0F, 4'h1, 1'b0, 9'h00C};
    vecs[6] = '{8'h00, 8'h00, 4'h0, 1'b1, 9'h000};
    vecs[7] = '{8'h7F, 8'h01, 4'h0, 1'b1, 9'h080};

    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_s = 1'b0;
    res_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", 32'(res_y), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_dp", {7'd0, dp_inA, dp_inB, dp_op, dp_s}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);
    @(negedge clk);
    chk("idle_dp_hold", 32'(dp_inA), 32'(vecs[7].a));

    // Back-to-back with the consumer stalled: four fill the FIFO, the fifth waits.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(8'(i * 16 + 1), 8'h02, 4'h0, i[0]);
      exp_q.push_back(model(8'(i * 16 + 1), 8'h02, 4'h0));
    end
    repeat (3) @(negedge clk);
    chk("full_res_valid", 32'(res_valid), 32'd1);
    chk("full_head", 32'(res_y), 32'(exp_q[0]));
    cmd_a = 8'h50; cmd_b = 8'h0A; cmd_op = 4'h0; cmd_s = 1'b1; cmd_valid = 1'b1;
    chk("full_blocked0", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("full_blocked3", 32'(cmd_ready), 32'd0);
    chk("full_not_busy", 32'(busy), 32'd0);
    res_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_pop_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_q.push_back(model(8'h50, 8'h0A, 4'h0));
    repeat (3) @(negedge clk);
    exp_done = (exp_done + 5) % 256;
    chk("burst_done_cnt", 32'(done_cnt), 32'(exp_done));
    drain("burst", 4);

    // Pop and capture on the same edge while two results are queued.
    issue(8'h11, 8'h22, 4'h0, 1'b0); exp_q.push_back(9'h033);
    issue(8'hF0, 8'h33, 4'h1, 1'b0); exp_q.push_back(9'h030);
    repeat (3) @(negedge clk);
    issue(8'hC0, 8'hC0, 4'h0, 1'b1); exp_q.push_back(9'h180);
    @(negedge clk);
    chk("same_cycle_head", 32'(res_y), 32'(exp_q[0]));
    res_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    res_ready = 1'b0;
    exp_done = (exp_done + 3) % 256;
    drain("same_cycle", 2);

    // Reset in WAIT with a result already queued aborts everything.
    issue(8'h01, 8'h01, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    issue(8'h02, 8'h02, 4'h0, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("mid_rst_dp", 32'(dp_inA), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_done = 0;
    run_vec(1);
    @(negedge clk);

    // Run the counter up to 255 and across the wrap.
    begin
      int errs = 0;
      int n = 0;
      res_ready = 1'b1;
      while (exp_done != 0 && n < 300) begin
        issue(8'(n), 8'(n) ^ 8'h5A, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        exp_done = (exp_done + 1) % 256;
        if (res_y !== model(8'(n), 8'(n) ^ 8'h5A, 4'h0) || !res_valid) errs++;
        if (exp_done == 255) chk("wrap_255", 32'(done_cnt), 32'd255);
        n++;
      end
      chk("wrap_0", 32'(done_cnt), 32'd0);
      chk("wrap_results", 32'(errs), 32'd0);
    end
    chk("ready_while_busy", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
